// File: rtl/speed_test_check_if.sv
// speed_test_check_if: tap bundle between a speed-test client and its checker.
//   Tap (driven by the environment, read by the checker):
//     nomangle - client mangle setting, 1 = odata should equal idata
//     idata    - byte stream presented to the client by RTEFI
//     raw_s    - RTEFI payload strobe
//     odata    - byte stream produced by the client
//   Results (driven by the checker):
//     pkt_count, bad_count, err_count, byte_count - saturating statistics
//     pkt_done, pkt_bad                          - end-of-packet strobe and verdict
//     first_off, first_xor, first_valid          - first-mismatch capture
interface speed_test_check_if #(
   parameter int cw = 16
);
   logic          nomangle;
   logic [7:0]    idata;
   logic          raw_s;
   logic [7:0]    odata;
   logic [cw-1:0] pkt_count;
   logic [cw-1:0] bad_count;
   logic [cw-1:0] err_count;
   logic [2*cw-1:0] byte_count;
   logic          pkt_done;
   logic          pkt_bad;
   logic [7:0]    first_off;
   logic [7:0]    first_xor;
   logic          first_valid;

   modport master (
      output nomangle, idata, raw_s, odata,
      input  pkt_count, bad_count, err_count, byte_count,
             pkt_done, pkt_bad, first_off, first_xor, first_valid
   );

   modport slave (
      input  nomangle, idata, raw_s, odata,
      output pkt_count, bad_count, err_count, byte_count,
             pkt_done, pkt_bad, first_off, first_xor, first_valid
   );
endinterface

// File: rtl/speed_test_check_reg_delay.sv
// reg_delay: plain len-stage register delay line with synchronous clear.
//   clk   - clock
//   reset - synchronous active-high clear of every stage
//   din   - data in
//   dout  - din delayed by len cycles (len = 0 is a wire)
module reg_delay #(
   parameter int len = 1,
   parameter int dw  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [dw-1:0] din,
   output logic [dw-1:0] dout
);
   generate
      if (len == 0) begin : g_pass
         assign dout = din;
      end else begin : g_sr
         logic [dw-1:0] sr [len];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < len; i++) sr[i] <= '0;
            end else begin
               sr[0] <= din;
               for (int i = 1; i < len; i++) sr[i] <= sr[i-1];
            end
         end

         assign dout = sr[len-1];
      end
   endgenerate
endmodule

// File: rtl/speed_test_check.sv
// speed_test_check: checks a speed-test client's output stream on-chip.
//   Rebuilds the expected (optionally offset-mangled) byte for every payload
//   byte, lines it up with the client's n_lat-cycle latency, compares, and
//   keeps saturating packet/byte/error statistics plus a first-error capture.
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - slave side of speed_test_check_if (tap inputs, result outputs)
module speed_test_check #(
   parameter int n_lat = 2,   // client latency, >= 1
   parameter int cw    = 16   // counter width; byte counter is 2*cw
) (
   input  logic               clk,
   input  logic               reset,
   speed_test_check_if.slave  bus
);
   localparam int OW = 8;     // offset counter width

   logic [OW-1:0] cnt, exp0, off0, exp_d, off_d;
   logic          raw0, en0, raw_d, en_d;
   logic          armed;

   // Stage 0: expected byte, strobe and offset for the byte at idata.
   // en0 carries "armed" alongside the data, so a packet that was already in
   // flight when reset released stays disabled all the way down the pipe.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         exp0  <= '0;
         off0  <= '0;
         raw0  <= 1'b0;
         en0   <= 1'b0;
         armed <= 1'b0;
      end else begin
         cnt   <= bus.raw_s ? cnt + 1'b1 : '0;
         exp0  <= bus.idata ^ (cnt & {OW{~bus.nomangle}});
         off0  <= cnt;
         raw0  <= bus.raw_s;
         en0   <= armed;
         armed <= armed | ~bus.raw_s;
      end
   end

   // Remaining n_lat-1 cycles of alignment with odata.
   generate
      if (n_lat == 1) begin : g_nodly
         assign {en_d, raw_d, exp_d} = {en0, raw0, exp0};
         assign off_d = off0;
      end else begin : g_dly
         reg_delay #(.len(n_lat-1), .dw(10)) u_dly_exp (
            .clk   (clk),
            .reset (reset),
            .din   ({en0, raw0, exp0}),
            .dout  ({en_d, raw_d, exp_d})
         );
         reg_delay #(.len(n_lat-1), .dw(OW)) u_dly_cnt (
            .clk   (clk),
            .reset (reset),
            .din   (off0),
            .dout  (off_d)
         );
      end
   endgenerate

   logic ce, ce_q, mism, fall, bad_flag;
   logic [cw-1:0]   pkt_count, bad_count, err_count;
   logic [2*cw-1:0] byte_count;
   logic            pkt_done, pkt_bad, first_valid;
   logic [OW-1:0]   first_off, first_xor;

   assign ce   = en_d & raw_d;
   assign mism = ce & (bus.odata != exp_d);
   assign fall = ce_q & ~raw_d;   // last compared byte was the previous cycle

   always_ff @(posedge clk) begin
      if (reset) begin
         ce_q        <= 1'b0;
         bad_flag    <= 1'b0;
         pkt_count   <= '0;
         bad_count   <= '0;
         err_count   <= '0;
         byte_count  <= '0;
         pkt_done    <= 1'b0;
         pkt_bad     <= 1'b0;
         first_valid <= 1'b0;
         first_off   <= '0;
         first_xor   <= '0;
      end else begin
         ce_q     <= ce;
         pkt_done <= fall;
         pkt_bad  <= fall & bad_flag;
         if (ce && byte_count != '1) byte_count <= byte_count + 1'b1;
         if (mism) begin
            bad_flag <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_valid) begin
               first_valid <= 1'b1;
               first_off   <= off_d;
               first_xor   <= bus.odata ^ exp_d;
            end
         end
         // fall and mism never coincide: ce is low on the falling cycle.
         if (fall) begin
            bad_flag <= 1'b0;
            if (pkt_count != '1) pkt_count <= pkt_count + 1'b1;
            if (bad_flag && bad_count != '1) bad_count <= bad_count + 1'b1;
         end
      end
   end

   assign bus.pkt_count   = pkt_count;
   assign bus.bad_count   = bad_count;
   assign bus.err_count   = err_count;
   assign bus.byte_count  = byte_count;
   assign bus.pkt_done    = pkt_done;
   assign bus.pkt_bad     = pkt_bad;
   assign bus.first_off   = first_off;
   assign bus.first_xor   = first_xor;
   assign bus.first_valid = first_valid;
endmodule

// File: tb/tb_speed_test_check.sv
// Bench for speed_test_check: a cw=16 checker plus a cw=4 checker on the same
// tap (the narrow one reaches saturation in a handful of packets).
module tb_speed_test_check;
   localparam int NL = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       nomangle = 1'b0;
   logic [7:0] idata = 8'h00;
   logic       raw_s = 1'b0;
   logic [7:0] odata;

   speed_test_check_if #(.cw(16)) bus ();
   speed_test_check_if #(.cw(4))  sbus ();

   assign bus.nomangle  = nomangle;
   assign bus.idata     = idata;
   assign bus.raw_s     = raw_s;
   assign bus.odata     = odata;
   assign sbus.nomangle = nomangle;
   assign sbus.idata    = idata;
   assign sbus.raw_s    = raw_s;
   assign sbus.odata    = odata;

   speed_test_check #(.n_lat(NL), .cw(16)) dut (.clk(clk), .reset(reset), .bus(bus));
   speed_test_check #(.n_lat(NL), .cw(4))  dut_s (.clk(clk), .reset(reset), .bus(sbus));

   // Client model: two-cycle latency, mangles with the low byte of the offset.
   // cor_idx/cor_val overwrite the output at one payload index (16-bit index,
   // so offset 256 is distinguishable from offset 0).
   logic [15:0] midx = '0, o1 = '0, o2 = '0;
   logic [7:0]  p1 = '0, p2 = '0;
   logic        r1 = 1'b0, r2 = 1'b0;
   int          cor_idx = -1;
   logic [7:0]  cor_val = '0;

   always @(posedge clk) begin
      midx <= raw_s ? midx + 16'd1 : 16'd0;
      p1   <= idata ^ (nomangle ? 8'h00 : midx[7:0]);
      o1   <= midx;
      r1   <= raw_s;
      p2   <= p1;
      o2   <= o1;
      r2   <= r1;
   end
   assign odata = (r2 && cor_idx >= 0 && int'(o2) == cor_idx) ? cor_val : p2;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   done_n = 0;
   logic last_bad = 1'b0;
   int   done_cyc[$];
   int   fall_cyc[$];
   always @(negedge clk) begin
      if (bus.pkt_done) begin
         done_n++;
         last_bad = bus.pkt_bad;
         done_cyc.push_back(cyc);
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One packet of len bytes idata = base + i*step, then gap low cycles.
   task automatic send(input int len, input logic [7:0] base, input logic [7:0] step,
                       input int gap);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         idata = base + 8'(i) * step;
         raw_s = 1'b1;
      end
      @(negedge clk);
      raw_s = 1'b0;
      idata = 8'h00;
      fall_cyc.push_back(cyc);
      repeat (gap - 1) @(negedge clk);
   endtask

   int base_n;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_pkt",   bus.pkt_count, 0);
      chk("rst_bad",   bus.bad_count, 0);
      chk("rst_err",   bus.err_count, 0);
      chk("rst_byte",  bus.byte_count, 0);
      chk("rst_done",  bus.pkt_done, 0);
      chk("rst_fv",    bus.first_valid, 0);

      // Clean 16-byte mangled packet
      send(16, 8'h00, 8'h01, 4);
      repeat (4) @(negedge clk);
      chk("t1_done_n", done_n, 1);
      chk("t1_bad",    last_bad, 0);
      chk("t1_pkt",    bus.pkt_count, 1);
      chk("t1_byte",   bus.byte_count, 16);
      chk("t1_err",    bus.err_count, 0);
      chk("t1_fv",     bus.first_valid, 0);

      // Same packet, byte 5 forced to 0xFF (expected 0x05^0x05 = 0x00)
      cor_idx = 5; cor_val = 8'hFF;
      send(16, 8'h00, 8'h01, 4);
      repeat (4) @(negedge clk);
      cor_idx = -1;
      chk("t2_done_n", done_n, 2);
      chk("t2_pkt_bad", last_bad, 1);
      chk("t2_err",    bus.err_count, 1);
      chk("t2_bad",    bus.bad_count, 1);
      chk("t2_pkt",    bus.pkt_count, 2);
      chk("t2_byte",   bus.byte_count, 32);
      chk("t2_off",    bus.first_off, 5);
      chk("t2_xor",    bus.first_xor, 8'hFF);
      chk("t2_fv",     bus.first_valid, 1);

      // 300-byte packet, nomangle=1, offset wraps past 255
      nomangle = 1'b1;
      send(300, 8'h03, 8'h07, 4);
      repeat (4) @(negedge clk);
      nomangle = 1'b0;
      chk("t3_err",    bus.err_count, 1);
      chk("t3_byte",   bus.byte_count, 332);
      chk("t3_pkt",    bus.pkt_count, 3);
      chk("t3_bad",    bus.bad_count, 1);

      // 300 bytes mangled; byte 256 is 3+256*7 = 0x03, expected 0x03^0x00
      cor_idx = 256; cor_val = 8'h03;
      send(300, 8'h03, 8'h07, 4);
      repeat (4) @(negedge clk);
      cor_idx = -1;
      chk("t3b_err",   bus.err_count, 1);
      chk("t3b_byte",  bus.byte_count, 632);
      chk("t3b_pkt",   bus.pkt_count, 4);
      chk("t3b_off",   bus.first_off, 5);
      chk("sat_byte",  sbus.byte_count, 8'hFF);
      chk("s_pkt4",    sbus.pkt_count, 4);

      // Two 4-byte packets separated by a single low cycle
      base_n = done_n;
      fall_cyc.delete();
      done_cyc.delete();
      send(4, 8'h20, 8'h01, 1);
      send(4, 8'h30, 8'h01, 4);
      repeat (4) @(negedge clk);
      chk("t4_done_n", done_n - base_n, 2);
      chk("t4_pkt",    bus.pkt_count, 6);
      chk("t4_byte",   bus.byte_count, 640);
      chk("t4_err",    bus.err_count, 1);
      chk("t4_nq",     done_cyc.size(), 2);
      if (done_cyc.size() >= 2 && fall_cyc.size() >= 2) begin
         chk("t4_lat0", done_cyc[0], fall_cyc[0] + NL + 1);
         chk("t4_lat1", done_cyc[1], fall_cyc[1] + NL + 1);
      end

      // Reset across bytes 3..4, released while raw_s is still high
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         idata = 8'(i);
         raw_s = 1'b1;
         reset = (i == 3 || i == 4);
      end
      @(negedge clk);
      raw_s = 1'b0;
      idata = 8'h00;
      repeat (6) @(negedge clk);
      chk("t5_pkt",    bus.pkt_count, 0);
      chk("t5_byte",   bus.byte_count, 0);
      chk("t5_err",    bus.err_count, 0);
      chk("t5_bad",    bus.bad_count, 0);
      chk("t5_fv",     bus.first_valid, 0);
      chk("t5_off",    bus.first_off, 0);
      send(8, 8'h40, 8'h01, 4);
      repeat (4) @(negedge clk);
      chk("t5b_pkt",   bus.pkt_count, 1);
      chk("t5b_byte",  bus.byte_count, 8);
      chk("t5b_err",   bus.err_count, 0);

      // 20 bad packets; first capture at offset 1: 0xA5 ^ (0x11^0x01) = 0xB5
      cor_idx = 1; cor_val = 8'hA5;
      send(2, 8'h10, 8'h01, 4);
      cor_idx = 0; cor_val = 8'h00;
      for (int k = 0; k < 19; k++) send(2, 8'h10, 8'h01, 4);
      repeat (4) @(negedge clk);
      cor_idx = -1;
      chk("t6_pkt",    bus.pkt_count, 21);
      chk("t6_bad",    bus.bad_count, 20);
      chk("t6_err",    bus.err_count, 20);
      chk("t6_byte",   bus.byte_count, 48);
      chk("t6_off",    bus.first_off, 1);
      chk("t6_xor",    bus.first_xor, 8'hB5);
      chk("t6_fv",     bus.first_valid, 1);
      chk("sat_pkt",   sbus.pkt_count, 4'hF);
      chk("sat_bad",   sbus.bad_count, 4'hF);
      chk("sat_err",   sbus.err_count, 4'hF);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/speed_test_check.md
Name: speed_test_check

Overview:
- Downstream checker for the speed-test client. Taps the same RTEFI client strobes and data the speed-test client sees, plus that client's odata.
- Regenerates the expected mangled byte stream, compares it byte by byte, and keeps packet, byte and error statistics plus first-error capture.
- Used in hardware self-test and on simulation benches, so loopback corruption is counted on-chip rather than only by host software.

Parameters:
- n_lat, 2, latency in cycles from idata to odata of the checked client; minimum 1; must equal the client's n_lat.
- cw, 16, width of packet and error counters; the byte counter is 2*cw bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- nomangle  input  1  same software setting as the checked client; 1 means expected odata equals idata
- idata  input  8  client input byte stream from RTEFI
- raw_s  input  1  RTEFI client data strobe, high for the UDP payload span
- odata  input  8  output byte of the checked client
- pkt_count  output  cw  packets completed, saturating
- bad_count  output  cw  packets with at least one mismatch, saturating
- err_count  output  cw  mismatched bytes, saturating
- byte_count  output  2*cw  bytes compared, saturating
- pkt_done  output  1  one-cycle strobe at the end of each checked packet
- pkt_bad  output  1  valid with pkt_done; 1 if that packet mismatched
- first_off  output  8  byte offset of the first mismatch since reset
- first_xor  output  8  odata XOR expected at the first mismatch
- first_valid  output  1  first_off and first_xor hold a capture

Behaviour:
- Reset (synchronous, active-high): every output goes to 0, delay lines clear, offset counter goes to 0, and armed clears.
  - Reset takes priority over all other events in the same cycle.
- Arming: armed sets on the first cycle raw_s is sampled low after reset. While unarmed, nothing is compared or counted. A packet already in flight when reset deasserts is therefore ignored entirely.
- Offset counter cnt (8 bits):
  - cnt <= raw_s ? cnt+1 : 0.
  - Wraps 255 -> 0 within long packets, so the expected pattern wraps identically.
- Expected path:
  - exp0 <= idata ^ (cnt & {8{~nomangle}}), registered.
  - exp0, raw_s and cnt are delayed by n_lat-1 further cycles through reg_delay, aligning them with odata.
  - Total alignment is n_lat cycles after idata.
- Compare enable ce = armed AND delayed raw_s.
- When ce is high:
  - byte_count increments.
  - If odata != aligned expected: err_count increments and the packet-error flag sets.
  - If first_valid is 0 at a mismatch: capture the aligned offset into first_off and the XOR into first_xor, and set first_valid. The capture holds until reset.
- End of packet: on a falling edge of delayed raw_s while armed, the next cycle has:
  - pkt_done = 1.
  - pkt_bad = packet-error flag.
  - pkt_count+1, and bad_count+1 if bad.
  - The packet-error flag clears in the same cycle.
- Back-to-back packets: raw_s low for a single cycle is a valid gap. The gap produces exactly one pkt_done and restarts cnt at 0.
- Saturation: each counter sticks at all-ones and never wraps.
- nomangle changing mid-packet is not supported. Expected values follow nomangle as sampled at the idata cycle.
- Latency: pkt_done asserts n_lat+1 cycles after the raw_s falling edge at the input.

Decomposition:
- No shared package. The 8-bit offset width is a localparam; counter width comes from cw.
- One sub-module: the existing reg_delay, instantiated with len=n_lat-1, dw=10 (exp0 + raw_s + a spare enable bit) plus a second instance for cnt. Wrap these in a local generate if n_lat=1, since len=0 is a pass-through.
- Saturating-increment logic is inline, not a module.

Test Plan:
- Reset then 16-byte packet idata=0x00..0x0F, nomangle=0, odata from a model with n_lat=2 -> pkt_done once, pkt_bad=0, pkt_count=1, byte_count=16, err_count=0, first_valid=0.
- Same packet with odata byte 5 forced to 0xFF -> err_count=1, bad_count=1, first_off=5, first_xor=0xFF^(0x05^0x05)=0xFF, first_valid=1.
- nomangle=1, model passes idata unchanged, 300-byte packet -> no errors, byte_count=300; cnt wraps at 256 with no false mismatch. Repeat with nomangle=0 and confirm the expected value at offset 256 is idata^0x00.
- Two packets of 4 bytes separated by a 1-cycle raw_s gap -> two pkt_done strobes n_lat+1 cycles after each falling edge, pkt_count=2.
- Reset asserted mid-packet at byte 3, released while raw_s still high -> remainder ignored, all outputs 0. The next full packet is counted normally.
- Force 65535+2 bad packets (cw=16) -> bad_count and pkt_count stick at 0xFFFF; first_off and first_xor unchanged after the first capture.
